// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-based prefetch into a DEPTH-entry FIFO of
// {instr, pc}, one-cycle memory latency, flush redirect and synchronous reset.
module fetch_queue #(
  parameter int unsigned       INSTR_W  = 20,
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_data,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          flush_addr,
  output logic                       ir_valid,
  output logic [INSTR_W-1:0]         ir_instr,
  output logic [ADDR_W-1:0]          ir_pc,
  input  logic                       ir_ready,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [ADDR_W-1:0]  fpc_q, fpc_d;
  logic [ADDR_W-1:0]  tag_q, tag_d;
  logic               pend_q, pend_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               issue, push, pop, has_head;
  entry_t             head;

  // Credit counts the in-flight word so every returning word has a slot.
  always_comb begin
    has_head = !reset && (count_q != '0);
    head     = mem_q[rd_ptr_q];
    issue    = !reset && !flush &&
               (({1'b0, count_q} + (CNT_W+1)'(pend_q)) < (CNT_W+1)'(DEPTH));
    push     = pend_q && !flush;
    pop      = has_head && ir_ready && !flush;

    fpc_d    = fpc_q;
    tag_d    = tag_q;
    pend_d   = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      fpc_d    = flush_addr;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        fpc_d = fpc_q + ADDR_W'(1);
        tag_d = fpc_q;
      end
      pend_d = issue;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q    <= RESET_PC;
      tag_q    <= '0;
      pend_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      fpc_q    <= fpc_d;
      tag_q    <= tag_d;
      pend_q   <= pend_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; reads are qualified by the entry count.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= '{instr: imem_data, pc: tag_q};
    end
  end

  assign imem_req  = issue;
  assign imem_addr = fpc_q;
  assign ir_valid  = has_head;
  assign ir_instr  = has_head ? head.instr : '0;
  assign ir_pc     = has_head ? head.pc    : '0;
  assign level     = reset ? '0 : count_q;

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter INSTR_W, default 20, instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 16, instruction address width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port imem_req  output  1  fetch issued to instruction memory this cycle.
REQ-008 SHALL have port imem_addr  output  ADDR_W  fetch address, valid when imem_req=1.
REQ-009 SHALL have port imem_data  input  INSTR_W  instruction word, valid the cycle after its request.
REQ-010 SHALL have port flush  input  1  redirect request; discards all queued and in-flight words.
REQ-011 SHALL have port flush_addr  input  ADDR_W  new fetch address, sampled when flush=1.
REQ-012 SHALL have port ir_valid  output  1  head entry available to the instruction register.
REQ-013 SHALL have port ir_instr  output  INSTR_W  head instruction word.
REQ-014 SHALL have port ir_pc  output  ADDR_W  address the head word was fetched from.
REQ-015 SHALL have port ir_ready  input  1  instruction register loads head this cycle.
REQ-016 SHALL have port level  output  $clog2(DEPTH)+1  number of valid queue entries.

Function
REQ-017 SHALL keep a fetch pointer fpc, a DEPTH-entry FIFO of {instr, pc}, and one in-flight flag pend with its tag address.
REQ-018 SHALL assert imem_req with imem_addr=fpc when flush=0 and (level + pend) < DEPTH; fpc increments by 1 on each issue.
REQ-019 SHALL wrap fpc from 2^ADDR_W-1 to 0 with no error indication.
REQ-020 SHALL, in the cycle after an issue, write imem_data with its tag address into the FIFO tail, unless cancelled by flush.
REQ-021 SHALL have no bypass: a word written in cycle N appears at ir_valid/ir_instr in cycle N+1 at the earliest.
REQ-022 SHALL drive ir_valid=1 whenever level>0; ir_instr/ir_pc reflect the head and hold stable until popped.
REQ-023 SHALL pop the head when ir_valid=1 and ir_ready=1; ir_ready with ir_valid=0 has no effect.
REQ-024 SHALL support push and pop in the same cycle; level unchanged.
REQ-025 SHALL never overflow: credit rule of REQ-018 guarantees space for every in-flight word.
REQ-026 SHALL, on flush=1: empty FIFO (level=0, ir_valid=0 next cycle), cancel any in-flight word, set fpc=flush_addr, issue no request that cycle.
REQ-027 SHALL treat flush as dominant over ir_ready and push in the same cycle; the popped/pushed word is discarded.
REQ-028 SHALL, after a flush in cycle F, issue flush_addr in F+1 and present it with ir_valid=1 in F+3.
REQ-029 SHALL keep the FIFO order equal to fetch order; ir_pc of consecutive entries differs by 1 (mod 2^ADDR_W) between flushes.

Reset
REQ-030 SHALL, while reset=1, force level=0, ir_valid=0, imem_req=0, pend=0, fpc=RESET_PC; ir_instr and ir_pc read 0.
REQ-031 SHALL discard any in-flight word when reset is asserted mid-operation.
REQ-032 SHALL issue the first request (imem_addr=RESET_PC) in the first cycle with reset=0; first ir_valid=1 two cycles later.
REQ-033 SHALL give reset priority over flush and ir_ready.

Verification
REQ-034 Reset release, ir_ready=0, DEPTH=4 -> requests at 0,1,2,3 in cycles 0-3, then imem_req=0, level=4, ir_pc=0.
REQ-035 Full queue, ir_ready=1 for one cycle -> head 0 popped, ir_pc=1, one new request at addr 4 next cycle, level returns to 4.
REQ-036 ir_ready held 1 continuously -> one instruction delivered per cycle, ir_pc 0,1,2,... with no bubbles after startup.
REQ-037 flush=1, flush_addr=0x0100 while level=3 and a request in flight -> level=0 next cycle, request 0x0100 at F+1, ir_pc=0x0100 valid at F+3, no stale word delivered.
REQ-038 RESET_PC=0xFFFE, ir_ready=1 -> ir_pc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-039 reset asserted with level=2 and one in flight -> next cycle level=0, ir_valid=0, imem_req=0; after release request at RESET_PC.
